// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: T_use/T_new data hazards,
// multiply/divide occupancy and a stall-cycle performance counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      instr_E,
  input  logic [31:0]      instr_M,
  output logic             stall,
  output logic             en_PC,
  output logic             en_FD,
  output logic             clr_DE,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  // Destination register, with 0 meaning "writes nothing" ($0 is never a real producer).
  function automatic logic [4:0] dest_of(input logic [31:0] i);
    logic [4:0] d;
    d = 5'd0;
    case (i[31:26])
      OP_RTYPE: begin
        case (i[5:0])
          FN_ADD, FN_SUB, FN_MFHI, FN_MFLO: d = i[15:11];
          default:                          d = 5'd0;
        endcase
      end
      OP_ORI, OP_LUI, OP_LW: d = i[20:16];
      OP_JAL:                d = 5'd31;
      default:               d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] tnew_e_of(input logic [31:0] i);
    logic [1:0] t;
    t = 2'd0;
    case (i[31:26])
      OP_LW:          t = 2'd2;
      OP_ORI, OP_LUI: t = 2'd1;
      OP_RTYPE: begin
        case (i[5:0])
          FN_ADD, FN_SUB, FN_MFHI, FN_MFLO: t = 2'd1;
          default:                          t = 2'd0;
        endcase
      end
      default:        t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic src_hazard(input logic used, input logic [4:0] r,
                                      input logic [1:0] tuse,
                                      input logic [4:0] d_e, input logic [1:0] tn_e,
                                      input logic [4:0] d_m, input logic [1:0] tn_m);
    return used && (r != 5'd0) &&
           (((r == d_e) && (tn_e > tuse)) || ((r == d_m) && (tn_m > tuse)));
  endfunction

  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic       mdu_in_d, start_e, div_e;
  logic [4:0] dest_e, dest_m;
  logic [1:0] tnew_e, tnew_m;
  logic       data_stall, mdu_stall;
  logic [3:0] cnt;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    tuse_rs  = 2'd0;
    tuse_rt  = 2'd0;
    mdu_in_d = 1'b0;
    case (instr_D[31:26])
      OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ORI, OP_LW: begin
        use_rs  = 1'b1;
        tuse_rs = 2'd1;
      end
      OP_SW: begin
        use_rs  = 1'b1;
        tuse_rs = 2'd1;
        use_rt  = 1'b1;
        tuse_rt = 2'd2;
      end
      OP_RTYPE: begin
        case (instr_D[5:0])
          FN_JR: use_rs = 1'b1;
          FN_ADD, FN_SUB: begin
            use_rs  = 1'b1;
            tuse_rs = 2'd1;
            use_rt  = 1'b1;
            tuse_rt = 2'd1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            use_rs   = 1'b1;
            tuse_rs  = 2'd1;
            use_rt   = 1'b1;
            tuse_rt  = 2'd1;
            mdu_in_d = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            use_rs   = 1'b1;
            tuse_rs  = 2'd1;
            mdu_in_d = 1'b1;
          end
          FN_MFHI, FN_MFLO: mdu_in_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign dest_e = dest_of(instr_E);
  assign dest_m = dest_of(instr_M);
  assign tnew_e = tnew_e_of(instr_E);
  assign tnew_m = (instr_M[31:26] == OP_LW) ? 2'd1 : 2'd0;

  assign div_e   = (instr_E[31:26] == OP_RTYPE) &&
                   ((instr_E[5:0] == FN_DIV) || (instr_E[5:0] == FN_DIVU));
  assign start_e = div_e || ((instr_E[31:26] == OP_RTYPE) &&
                   ((instr_E[5:0] == FN_MULT) || (instr_E[5:0] == FN_MULTU)));

  assign data_stall = src_hazard(use_rs, instr_D[25:21], tuse_rs, dest_e, tnew_e, dest_m, tnew_m) ||
                      src_hazard(use_rt, instr_D[20:16], tuse_rt, dest_e, tnew_e, dest_m, tnew_m);

  // Busy is masked while reset is asserted so an aborted divide never holds off D.
  assign mdu_busy  = reset && (cnt != 4'd0);
  assign mdu_stall = mdu_in_d && (mdu_busy || start_e);

  assign stall  = data_stall || mdu_stall;
  assign en_PC  = ~stall;
  assign en_FD  = ~stall;
  assign clr_DE = stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (start_e) begin
      cnt <= div_e ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  logic unused_fields;
  assign unused_fields = ^{instr_D[15:6], instr_E[25:21], instr_E[10:6],
                           instr_M[25:21], instr_M[10:6]};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, hand-written MDU/reset/wrap sequences
// and random traffic, all checked against a rule-level reference model.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, instr_E, instr_M;
  logic        stall, en_PC, en_FD, clr_DE, mdu_busy;
  logic [31:0] stall_cnt;
  logic        stall4, en_PC4, en_FD4, clr_DE4, mdu_busy4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .stall(stall), .en_PC(en_PC), .en_FD(en_FD), .clr_DE(clr_DE),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .stall(stall4), .en_PC(en_PC4), .en_FD(en_FD4), .clr_DE(clr_DE4),
    .mdu_busy(mdu_busy4), .stall_cnt(stall_cnt4)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: per-instruction source/destination timing and an MDU free-at cycle.
  typedef struct {
    int rs_use;   // -1 = not a source
    int rt_use;
    int dest;
    int tnew_e;
    int tnew_m;
    bit mdu_d;
    int start_n;  // busy cycles started when in E, 0 = none
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t r;
    int op, fn, rt, rd;
    op = int'(i[31:26]); fn = int'(i[5:0]); rt = int'(i[20:16]); rd = int'(i[15:11]);
    r = '{-1, -1, 0, 0, 0, 1'b0, 0};
    case (op)
      'h23: begin r.rs_use = 1; r.dest = rt; r.tnew_e = 2; r.tnew_m = 1; end
      'h2B: begin r.rs_use = 1; r.rt_use = 2; end
      'h04: begin r.rs_use = 0; r.rt_use = 0; end
      'h0D: begin r.rs_use = 1; r.dest = rt; r.tnew_e = 1; end
      'h0F: begin r.dest = rt; r.tnew_e = 1; end
      'h03: begin r.dest = 31; end
      'h00: begin
        case (fn)
          'h20, 'h22: begin r.rs_use = 1; r.rt_use = 1; r.dest = rd; r.tnew_e = 1; end
          'h08:       r.rs_use = 0;
          'h18, 'h19: begin r.rs_use = 1; r.rt_use = 1; r.mdu_d = 1; r.start_n = 5; end
          'h1A, 'h1B: begin r.rs_use = 1; r.rt_use = 1; r.mdu_d = 1; r.start_n = 10; end
          'h10, 'h12: begin r.dest = rd; r.tnew_e = 1; r.mdu_d = 1; end
          'h11, 'h13: begin r.rs_use = 1; r.mdu_d = 1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit model_stall(input logic [31:0] d, input logic [31:0] e,
                                     input logic [31:0] m, input bit busy);
    dec_t dd, de, dm;
    int regs[2];
    int uses[2];
    bit s;
    dd = decode(d); de = decode(e); dm = decode(m);
    regs[0] = int'(d[25:21]); uses[0] = dd.rs_use;
    regs[1] = int'(d[20:16]); uses[1] = dd.rt_use;
    s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (uses[k] >= 0 && regs[k] != 0) begin
        if (regs[k] == de.dest && de.tnew_e > uses[k]) s = 1'b1;
        if (regs[k] == dm.dest && dm.tnew_m > uses[k]) s = 1'b1;
      end
    end
    if (dd.mdu_d && (busy || de.start_n != 0)) s = 1'b1;
    return s;
  endfunction

  int               mcyc = 0;
  int               busy_until = -1;
  longint unsigned  scnt = 0;
  bit               dut_stall_seen;

  task automatic step(input bit rn, input logic [31:0] d, input logic [31:0] e,
                      input logic [31:0] m, input bit do_chk);
    bit busy, s;
    dec_t de;
    @(negedge clk);
    reset = rn; instr_D = d; instr_E = e; instr_M = m;
    #1;
    busy = rn && (mcyc <= busy_until);
    s = model_stall(d, e, m, busy);
    dut_stall_seen = stall;
    if (do_chk) begin
      chk("stall", stall, s);
      chk("en_PC", en_PC, !s);
      chk("en_FD", en_FD, !s);
      chk("clr_DE", clr_DE, s);
      chk("mdu_busy", mdu_busy, busy);
      chk("stall_cnt", stall_cnt, scnt & 64'hFFFF_FFFF);
      chk("stall_cnt4", stall_cnt4, scnt & 64'hF);
    end
    de = decode(e);
    if (!rn) begin
      scnt = 0;
      busy_until = mcyc;
    end else begin
      if (s) scnt++;
      if (de.start_n != 0) busy_until = mcyc + de.start_n;
    end
    mcyc++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [5:0] fns[11];
    int k;
    fns = '{6'h20, 6'h22, 6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13};
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 9);
    case (k)
      0: return {6'h23, a, b, 16'h0004};
      1: return {6'h2B, a, b, 16'h0008};
      2: return {6'h04, a, b, 16'h0002};
      3: return {6'h0D, a, b, 16'h0001};
      4: return {6'h0F, a, b, 16'h1234};
      5: return {6'h03, 26'h0000010};
      6: return $urandom();
      default: return {6'h00, a, b, c, 5'd0, fns[$urandom_range(0, 10)]};
    endcase
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] m;
    bit          exp;
  } vec_t;

  localparam logic [31:0] LW8    = 32'h8C08_0000;
  localparam logic [31:0] ADD988 = 32'h0108_4820;
  localparam logic [31:0] DIV12  = 32'h0022_001A;
  localparam logic [31:0] MFLO3  = 32'h0000_1812;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{ADD988,       LW8,          32'h0,        1'b1}; // load-use
    vecs[1]  = '{ADD988,       32'h0,        LW8,          1'b0}; // lw in M, bubble in E
    vecs[2]  = '{32'h10A0_0003, 32'h3405_0001, 32'h0,       1'b1}; // beq after ori
    vecs[3]  = '{32'h10A0_0003, 32'h0,        32'h3405_0001, 1'b0};
    vecs[4]  = '{32'h0000_0820, 32'h8C00_0000, 32'h0,       1'b0}; // lw $0
    vecs[5]  = '{ADD988,       32'hAC08_0000, 32'h0,        1'b0}; // sw in E
    vecs[6]  = '{32'hAD28_0000, LW8,          32'h0,        1'b0}; // sw data rt late use
    vecs[7]  = '{32'hAD28_0000, 32'h8C09_0000, 32'h0,       1'b1}; // sw base from lw
    vecs[8]  = '{32'h03E0_0008, 32'h0C00_0000, 32'h0,       1'b0}; // jr after jal
    vecs[9]  = '{32'h03E0_0008, 32'h0,        32'h8C1F_0000, 1'b1}; // jr, lw $31 in M
    vecs[10] = '{32'h03E0_0008, 32'h0021_F820, 32'h0,       1'b1}; // jr, add $31 in E
    vecs[11] = '{32'h3486_0000, 32'h3C04_0000, 32'h0,       1'b0}; // ori after lui
    vecs[12] = '{32'h1004_0000, 32'h3C04_0000, 32'h0,       1'b1}; // beq rt after lui
    vecs[13] = '{32'h00E0_0011, 32'h0000_3810, 32'h0,       1'b0}; // mthi after mfhi

    reset = 1'b0; instr_D = '0; instr_E = '0; instr_M = '0;
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("reset_busy", mdu_busy, 0);
    chk("reset_cnt", stall_cnt, 0);

    foreach (vecs[k]) begin
      step(1'b1, vecs[k].d, vecs[k].e, vecs[k].m, 1'b1);
      chk($sformatf("vec%0d_stall", k), dut_stall_seen, vecs[k].exp);
    end

    // MDU: div in E at t, mflo waiting in D
    begin
      longint unsigned base;
      base = scnt;
      step(1'b1, MFLO3, DIV12, 32'h0, 1'b1);
      chk("mdu_t_stall", dut_stall_seen, 1);
      for (int i = 1; i <= 10; i++) begin
        step(1'b1, MFLO3, 32'h0, 32'h0, 1'b1);
        chk($sformatf("mdu_busy_t+%0d", i), mdu_busy, 1);
        chk($sformatf("mdu_stall_t+%0d", i), dut_stall_seen, 1);
      end
      step(1'b1, MFLO3, 32'h0, 32'h0, 1'b1);
      chk("mdu_t+11_stall", dut_stall_seen, 0);
      chk("mdu_t+11_busy", mdu_busy, 0);
      chk("mdu_stall_adv", stall_cnt, (base + 11) & 64'hFFFF_FFFF);
    end

    // Reset in the middle of a divide
    step(1'b1, 32'h0, DIV12, 32'h0, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("pre_reset_busy", mdu_busy, 1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    step(1'b1, MFLO3, 32'h0, 32'h0, 1'b1);
    chk("rst_mid_busy", mdu_busy, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    chk("rst_mid_stall", dut_stall_seen, 0);

    // Counter wrap on the 4-bit instance
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, ADD988, LW8, 32'h0, 1'b1);
    step(1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("wrap_cnt4", stall_cnt4, 1);
    chk("wrap_cnt32", stall_cnt, 17);

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) != 0), rand_instr(), rand_instr(), rand_instr(), 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
